// File: rtl/cfe_update_scheduler.sv
// Schedules carrier-frequency estimations: times the feedback interval, handshakes the
// estimation request, guards the measurement with a timeout and forwards accepted FO results.
module cfe_update_scheduler #(
    parameter int CFE_NBW_FO  = 13,
    parameter int CFE_NBW_LAT = 32,
    parameter int CFE_TIMEOUT = 1024,
    parameter int CFE_NBW_ERR = 8
) (
    input  logic                   clk,
    input  logic                   rst_async_n,
    input  logic                   i_enable,
    input  logic                   i_force,
    input  logic [CFE_NBW_LAT-1:0] i_wait,
    output logic                   o_cfe_req,
    input  logic                   i_cfe_ack,
    input  logic                   i_cfe_valid,
    input  logic [CFE_NBW_FO-1:0]  i_cfe_fo,
    output logic                   o_fo_valid,
    output logic [CFE_NBW_FO-1:0]  o_fo_value,
    output logic                   o_timeout,
    output logic [CFE_NBW_ERR-1:0] o_err_cnt,
    output logic                   o_busy
);

    localparam int NBW_TO = $clog2(CFE_TIMEOUT + 1);
    localparam logic [CFE_NBW_LAT-1:0] LAT_ONE = CFE_NBW_LAT'(1);
    localparam logic [NBW_TO-1:0]      TO_ONE  = NBW_TO'(1);
    localparam logic [NBW_TO-1:0]      TO_INIT = NBW_TO'(CFE_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_REQ   = 3'd2,
        ST_MEAS  = 3'd3,
        ST_APPLY = 3'd4
    } state_t;

    state_t                 state_r;
    logic [CFE_NBW_LAT-1:0] wait_cnt_r;
    logic [NBW_TO-1:0]      to_cnt_r;
    logic                   cfe_req_r;
    logic                   fo_valid_r;
    logic [CFE_NBW_FO-1:0]  fo_value_r;
    logic                   timeout_r;
    logic [CFE_NBW_ERR-1:0] err_cnt_r;
    logic                   busy_r;
    logic [CFE_NBW_LAT-1:0] wait_load_s;

    // Saturating increment so the error count sticks at all-ones.
    function automatic logic [CFE_NBW_ERR-1:0] sat_inc(input logic [CFE_NBW_ERR-1:0] val);
        if (&val) begin
            sat_inc = val;
        end else begin
            sat_inc = val + CFE_NBW_ERR'(1);
        end
    endfunction

    // Interval reload value; a zero interval would never expire, so it runs as one cycle.
    always_comb begin
        wait_load_s = i_wait;
        if (i_wait == '0) begin
            wait_load_s = LAT_ONE;
        end else begin
            wait_load_s = i_wait;
        end
    end

    // Scheduler FSM with registered outputs; disable has priority over every state.
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= '0;
            to_cnt_r   <= '0;
            cfe_req_r  <= 1'b0;
            fo_valid_r <= 1'b0;
            fo_value_r <= '0;
            timeout_r  <= 1'b0;
            err_cnt_r  <= '0;
            busy_r     <= 1'b0;
        end else begin
            fo_valid_r <= 1'b0;
            timeout_r  <= 1'b0;
            if (!i_enable) begin
                state_r   <= ST_IDLE;
                cfe_req_r <= 1'b0;
                busy_r    <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r    <= ST_WAIT;
                        wait_cnt_r <= wait_load_s;
                        busy_r     <= 1'b1;
                    end
                    ST_WAIT: begin
                        if ((wait_cnt_r == LAT_ONE) || i_force) begin
                            state_r   <= ST_REQ;
                            cfe_req_r <= 1'b1;
                        end else begin
                            wait_cnt_r <= wait_cnt_r - LAT_ONE;
                        end
                    end
                    ST_REQ: begin
                        if (i_cfe_ack) begin
                            state_r   <= ST_MEAS;
                            cfe_req_r <= 1'b0;
                            to_cnt_r  <= TO_INIT;
                        end else begin
                            cfe_req_r <= 1'b1;
                        end
                    end
                    ST_MEAS: begin
                        // A result arriving in the expiry cycle still counts as success.
                        if (i_cfe_valid) begin
                            state_r    <= ST_APPLY;
                            fo_value_r <= i_cfe_fo;
                            fo_valid_r <= 1'b1;
                        end else if (to_cnt_r == TO_ONE) begin
                            state_r    <= ST_WAIT;
                            wait_cnt_r <= wait_load_s;
                            timeout_r  <= 1'b1;
                            err_cnt_r  <= sat_inc(err_cnt_r);
                        end else begin
                            to_cnt_r <= to_cnt_r - TO_ONE;
                        end
                    end
                    ST_APPLY: begin
                        state_r    <= ST_WAIT;
                        wait_cnt_r <= wait_load_s;
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        cfe_req_r <= 1'b0;
                        busy_r    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_cfe_req  = cfe_req_r;
    assign o_fo_valid = fo_valid_r;
    assign o_fo_value = fo_value_r;
    assign o_timeout  = timeout_r;
    assign o_err_cnt  = err_cnt_r;
    assign o_busy     = busy_r;

endmodule

// File: tb/tb_cfe_update_scheduler.sv
// Directed bench for cfe_update_scheduler: a cycle table for the nominal round,
// then hand sequences for timeout, force, disable, async reset and error saturation.
module tb_cfe_update_scheduler;

    localparam int NFO  = 13;
    localparam int NLAT = 32;
    localparam int NTO  = 16;
    localparam int NERR = 8;

    logic            clk = 1'b0;
    logic            rst_async_n = 1'b0;
    logic            i_enable = 1'b0;
    logic            i_force = 1'b0;
    logic [NLAT-1:0] i_wait = '0;
    logic            o_cfe_req;
    logic            i_cfe_ack = 1'b0;
    logic            i_cfe_valid = 1'b0;
    logic [NFO-1:0]  i_cfe_fo = '0;
    logic            o_fo_valid;
    logic [NFO-1:0]  o_fo_value;
    logic            o_timeout;
    logic [NERR-1:0] o_err_cnt;
    logic            o_busy;

    int checks = 0;
    int errors = 0;

    cfe_update_scheduler #(
        .CFE_NBW_FO (NFO),
        .CFE_NBW_LAT(NLAT),
        .CFE_TIMEOUT(NTO),
        .CFE_NBW_ERR(NERR)
    ) dut (
        .clk        (clk),
        .rst_async_n(rst_async_n),
        .i_enable   (i_enable),
        .i_force    (i_force),
        .i_wait     (i_wait),
        .o_cfe_req  (o_cfe_req),
        .i_cfe_ack  (i_cfe_ack),
        .i_cfe_valid(i_cfe_valid),
        .i_cfe_fo   (i_cfe_fo),
        .o_fo_valid (o_fo_valid),
        .o_fo_value (o_fo_value),
        .o_timeout  (o_timeout),
        .o_err_cnt  (o_err_cnt),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            en;
        logic            frc;
        logic [NLAT-1:0] wt;
        logic            ack;
        logic            vld;
        logic [NFO-1:0]  fo;
        logic            e_req;
        logic            e_fv;
        logic [NFO-1:0]  e_fo;
        logic            e_to;
        logic            e_busy;
        logic [NERR-1:0] e_err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int n_to;
        bit seen;
        bit excl_bad;

        // Reset state
        #12;
        check("reset_outputs", {o_cfe_req, o_fo_valid, o_fo_value, o_timeout, o_err_cnt, o_busy}, 64'd0);
        @(negedge clk);
        rst_async_n = 1'b1;
        @(posedge clk);
        #1;

        // Nominal round: interval 5, ack two cycles into REQ, valid three cycles after ack
        for (int i = 0; i < 12; i++) begin
            vecs[i] = '{1'b1, 1'b0, 32'd5, 1'b0, 1'b0, 13'h0000,
                        1'b0, 1'b0, 13'h0000, 1'b0, 1'b1, 8'd0};
        end
        vecs[5].e_req  = 1'b1;
        vecs[6].e_req  = 1'b1;
        vecs[7].ack    = 1'b1;
        vecs[10].vld   = 1'b1;
        vecs[10].fo    = 13'h0123;
        vecs[10].e_fv  = 1'b1;
        vecs[10].e_fo  = 13'h0123;
        vecs[11].e_fo  = 13'h0123;

        for (int i = 0; i < 12; i++) begin
            i_enable    = vecs[i].en;
            i_force     = vecs[i].frc;
            i_wait      = vecs[i].wt;
            i_cfe_ack   = vecs[i].ack;
            i_cfe_valid = vecs[i].vld;
            i_cfe_fo    = vecs[i].fo;
            step();
            check($sformatf("vec%0d", i),
                  {o_cfe_req, o_fo_valid, o_fo_value, o_timeout, o_busy, o_err_cnt},
                  {vecs[i].e_req, vecs[i].e_fv, vecs[i].e_fo, vecs[i].e_to, vecs[i].e_busy, vecs[i].e_err});
        end
        i_cfe_ack = 1'b0;
        i_cfe_valid = 1'b0;

        // Timeout: ack but no valid; next interval uses the new i_wait of 3
        i_wait = 32'd3;
        k = 0;
        while (!o_cfe_req && k < 20) begin
            step();
            k++;
        end
        check("t2_req_seen", o_cfe_req, 1'b1);
        i_cfe_ack = 1'b1;
        step();
        i_cfe_ack = 1'b0;
        k = 0;
        while (!o_timeout && k < 40) begin
            step();
            k++;
        end
        check("t2_timeout_latency", k, 16);
        check("t2_err_cnt", o_err_cnt, 8'd1);
        check("t2_fo_valid_clear", o_fo_valid, 1'b0);
        step();
        step();
        check("t2_pulse_and_wait", {o_timeout, o_cfe_req, o_busy}, 3'b001);
        step();
        check("t2_req_after_3", o_cfe_req, 1'b1);

        // Valid coincident with timeout expiry
        i_cfe_ack = 1'b1;
        step();
        i_cfe_ack = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (o_timeout || o_fo_valid) seen = 1'b1;
        end
        check("t3_quiet_meas", seen, 1'b0);
        i_cfe_valid = 1'b1;
        i_cfe_fo = 13'h0AAA;
        step();
        i_cfe_valid = 1'b0;
        check("t3_valid_wins", {o_fo_valid, o_timeout, o_err_cnt, o_fo_value}, {1'b1, 1'b0, 8'd1, 13'h0AAA});

        // Force 10 cycles into a 100-cycle interval
        i_wait = 32'd100;
        step();
        check("t4_apply_done", {o_fo_valid, o_cfe_req}, 2'b00);
        for (int i = 0; i < 9; i++) step();
        check("t4_no_req_yet", o_cfe_req, 1'b0);
        i_force = 1'b1;
        step();
        i_force = 1'b0;
        check("t4_force_req", o_cfe_req, 1'b1);

        // Zero interval behaves as one cycle
        i_cfe_ack = 1'b1;
        step();
        i_cfe_ack = 1'b0;
        i_cfe_valid = 1'b1;
        i_cfe_fo = 13'h1ABC;
        step();
        i_cfe_valid = 1'b0;
        i_wait = 32'd0;
        check("t4_fo_1abc", {o_fo_valid, o_fo_value}, {1'b1, 13'h1ABC});
        step();
        check("t4_wait0_entry", o_cfe_req, 1'b0);
        step();
        check("t4_wait0_req", o_cfe_req, 1'b1);

        // Disable during MEAS, then a stray valid
        i_cfe_ack = 1'b1;
        step();
        i_cfe_ack = 1'b0;
        i_enable = 1'b0;
        step();
        check("t5_idle", {o_busy, o_cfe_req, o_timeout}, 3'b000);
        i_cfe_valid = 1'b1;
        i_cfe_fo = 13'h0555;
        step();
        i_cfe_valid = 1'b0;
        check("t5_ignored_valid", {o_fo_valid, o_fo_value, o_busy, o_err_cnt}, {1'b0, 13'h1ABC, 1'b0, 8'd1});

        // Asynchronous reset off the clock edge while in REQ
        i_enable = 1'b1;
        i_wait = 32'd1;
        step();
        step();
        check("t6_in_req", o_cfe_req, 1'b1);
        #3;
        rst_async_n = 1'b0;
        #1;
        check("t6_async_reset", {o_cfe_req, o_busy, o_err_cnt, o_fo_value}, 23'd0);
        @(negedge clk);
        rst_async_n = 1'b1;

        // 256 forced timeouts saturate the 8-bit error counter
        i_cfe_ack = 1'b1;
        n_to = 0;
        k = 0;
        excl_bad = 1'b0;
        while (n_to < 256 && k < 6000) begin
            step();
            k++;
            if (o_timeout) n_to++;
            if (o_timeout && o_fo_valid) excl_bad = 1'b1;
        end
        check("t6_timeouts_seen", n_to, 256);
        check("t6_err_saturated", o_err_cnt, 8'd255);
        check("t6_exclusive", excl_bad, 1'b0);
        i_cfe_ack = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
